_fifo_en_reg: RTL and testbench
===============================

// Module: _fifo_en_reg
// PURPOSE
//  Synchronous FIFO whose storage is a bank of enabled D registers.
//  Each entry loads only when its write enable is asserted, the same way an enabled D flip-flop does.
//  Sits directly downstream of the enabled-DFF datapath and buffers the words that datapath produces.
//  A consumer drains the words later, in arrival order.
//  Reports status and per-request acknowledge/error handshakes.
// PARAMETERS
//  WIDTH   32  data word width in bits
//  DEPTH   8   number of entries; must be a power of two, >= 2
//  AW      3   pointer width = log2(DEPTH); must match DEPTH
// PORTS
//  clk         in   1        rising-edge clock
//  reset_n     in   1        asynchronous active-low reset
//  wr_en       in   1        write request, sampled on rising clk
//  rd_en       in   1        read request, sampled on rising clk
//  din         in   WIDTH    write data, sampled with wr_en
//  dout        out  WIDTH    read data, registered
//  full        out  1        data_count == DEPTH
//  empty       out  1        data_count == 0
//  wr_ack      out  1        previous-cycle write accepted
//  wr_err      out  1        previous-cycle write rejected (FIFO full)
//  rd_ack      out  1        previous-cycle read accepted; dout valid
//  rd_err      out  1        previous-cycle read rejected (FIFO empty)
//  data_count  out  AW+1     number of stored words, 0..DEPTH
// BEHAVIOUR
//  - Reset (reset_n=0, async, no clock needed):
//    - head=0, tail=0, data_count=0, dout=0.
//    - empty=1, full=0; wr_ack, wr_err, rd_ack and rd_err all 0.
//    - Storage contents are don't-care.
//    - Reset mid-operation discards all stored words.
//  - Status flags derive from the pointers and data_count. Evaluation at each edge uses the pre-edge count.
//  - FSM, 3 states, next state from the pre-edge count and the accepted ops:
//    - INIT (count=0)
//      - accepted write -> NORMAL.
//      - DEPTH=1 is unsupported.
//    - NORMAL (0<count<DEPTH)
//      - accepted write only, count==DEPTH-1 -> FULL.
//      - accepted read only, count==1 -> INIT.
//    - FULL (count=DEPTH)
//      - accepted read -> NORMAL.
//  - Write accepted iff wr_en=1 and state!=FULL.
//    - mem[tail] <= din, tail <= tail+1 (wraps DEPTH-1 -> 0).
//    - Next cycle: wr_ack=1, wr_err=0.
//  - Write rejected (wr_en=1, FULL): storage and tail unchanged; next cycle wr_ack=0, wr_err=1.
//  - Read accepted iff rd_en=1 and state!=INIT.
//    - dout <= mem[head], head <= head+1 (wraps).
//    - Next cycle: rd_ack=1, rd_err=0.
//    - Read latency is 1 clk.
//  - Read rejected (rd_en=1, INIT): dout holds its value; next cycle rd_ack=0, rd_err=1.
//  - No request: the corresponding ack and err go to 0. dout holds its last value.
//  - Simultaneous wr_en and rd_en:
//    - NORMAL: both accepted; count unchanged; state unchanged.
//    - INIT: write accepted, read rejected (rd_err=1); count 0 -> 1.
//    - FULL: read accepted, write rejected (wr_err=1); count DEPTH -> DEPTH-1.
//    - A word is never written and read in the same cycle.
//  - Count arithmetic: +1 on write-only accept, -1 on read-only accept, otherwise unchanged.
//  - Count never exceeds DEPTH and never goes below 0.
// TESTING
//  1. Reset then idle 3 clk -> empty=1, full=0, data_count=0, dout=0, all ack/err 0.
//  2. Write 0x11..0x88 (8 words) -> wr_ack=1 on each.
//     - data_count steps 1..8.
//     - full=1 after the 8th write.
//     - 9th write 0x99 -> wr_err=1; data_count stays 8.
//  3. From full, read 8 times -> dout=0x11..0x88 in order, each valid 1 clk after rd_en with rd_ack=1.
//     - empty=1 at end.
//     - 9th read -> rd_err=1; dout holds 0x88.
//  4. Wrap: write 5, read 5, write 6, read 6 -> data order preserved across the pointer wrap; count returns to 0.
//  5. Simultaneous wr/rd:
//     - empty -> rd_err=1, count=1.
//     - count=3 -> count stays 3; oldest word on dout.
//     - full -> wr_err=1, count=7.
//  6. Assert reset_n=0 mid-clock with count=4 -> outputs go to reset values immediately, without a clk edge.
//     - After release, first read -> rd_err=1.

Source files
------------

// File: rtl/_fifo_en_reg.sv
// Synchronous FIFO built from a bank of enabled D registers, with a three-state
// occupancy FSM and registered per-request acknowledge/error handshakes.
module _fifo_en_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [AW:0]      data_count
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [AW:0] LAST_CNT  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] entry_en;
  logic             wr_accept;
  logic             rd_accept;

  // Acceptance depends only on the registered state, so a write and a read
  // can never touch the same entry in one cycle.
  assign wr_accept = wr_en && (state != ST_FULL);
  assign rd_accept = rd_en && (state != ST_INIT);

  assign full  = (data_count == DEPTH_CNT);
  assign empty = (data_count == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_en[gi] = wr_accept && (tail == AW'(gi));

      always_ff @(posedge clk) begin
        if (entry_en[gi]) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      wr_ack <= wr_accept;
      wr_err <= wr_en && !wr_accept;
      rd_ack <= rd_accept;
      rd_err <= rd_en && !rd_accept;

      if (wr_accept) begin
        tail <= tail + AW'(1);
      end
      if (rd_accept) begin
        dout <= mem[head];
        head <= head + AW'(1);
      end

      case ({wr_accept, rd_accept})
        2'b10:   data_count <= data_count + CW'(1);
        2'b01:   data_count <= data_count - CW'(1);
        default: data_count <= data_count;
      endcase

      // Transitions use the pre-edge count; a simultaneous accept leaves it unchanged.
      case (state)
        ST_INIT: begin
          if (wr_accept) state <= ST_NORMAL;
        end
        ST_NORMAL: begin
          if (wr_accept && !rd_accept && data_count == LAST_CNT) begin
            state <= ST_FULL;
          end else if (rd_accept && !wr_accept && data_count == CW'(1)) begin
            state <= ST_INIT;
          end
        end
        ST_FULL: begin
          if (rd_accept) state <= ST_NORMAL;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb__fifo_en_reg.sv
// Directed-vector bench for _fifo_en_reg: stimulus pushes hand-computed responses
// into a scoreboard queue, and a monitor pops and compares whenever a handshake appears.
module tb__fifo_en_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
  logic [3:0]  data_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        wa;
    logic        we;
    logic        ra;
    logic        re;
    logic [31:0] dout;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
  } exp_t;

  exp_t exp_q[$];

  _fifo_en_reg #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic check_idle_state(input string nm, input logic [31:0] exp_dout);
    check({nm, ".empty"},      32'(empty), 32'd1);
    check({nm, ".full"},       32'(full), 32'd0);
    check({nm, ".data_count"}, 32'(data_count), 32'd0);
    check({nm, ".dout"},       dout, exp_dout);
    check({nm, ".handshakes"}, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
  endtask

  // One request cycle; expected values are supplied by the caller.
  task automatic req(input logic w, input logic r, input logic [31:0] d,
                     input logic ewa, input logic ewe, input logic era, input logic ere,
                     input logic [31:0] edout, input logic [3:0] ecnt, input string nm);
    exp_t e;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    e.name  = nm;
    e.wa    = ewa;
    e.we    = ewe;
    e.ra    = era;
    e.re    = ere;
    e.dout  = edout;
    e.cnt   = ecnt;
    e.full  = (ecnt == 4'd8);
    e.empty = (ecnt == 4'd0);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 32'h0;
  endtask

  // Monitor: every handshake the DUT presents must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_ack || wr_err || rd_ack || rd_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".wr_ack"},     32'(wr_ack), 32'(e.wa));
          check({e.name, ".wr_err"},     32'(wr_err), 32'(e.we));
          check({e.name, ".rd_ack"},     32'(rd_ack), 32'(e.ra));
          check({e.name, ".rd_err"},     32'(rd_err), 32'(e.re));
          check({e.name, ".dout"},       dout, e.dout);
          check({e.name, ".data_count"}, 32'(data_count), 32'(e.cnt));
          check({e.name, ".full"},       32'(full), 32'(e.full));
          check({e.name, ".empty"},      32'(empty), 32'(e.empty));
          $display("txn %s: dout=0x%0h count=%0d ack/err=%b%b%b%b",
                   e.name, dout, data_count, wr_ack, wr_err, rd_ack, rd_err);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = 32'h0;
    #1;
    check_idle_state("in_reset", 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset
    repeat (3) @(posedge clk);
    #2;
    check_idle_state("idle_after_reset", 32'h0);

    // Fill to full, then one rejected write
    for (int i = 1; i <= 8; i++)
      req(1'b1, 1'b0, 32'(i * 17), 1, 0, 0, 0, 32'h0, 4'(i), $sformatf("wr%0d", i));
    req(1'b1, 1'b0, 32'h99, 0, 1, 0, 0, 32'h0, 4'd8, "wr_when_full");

    // Drain in order, then one rejected read
    for (int i = 1; i <= 8; i++)
      req(1'b0, 1'b1, 32'h0, 0, 0, 1, 0, 32'(i * 17), 4'(8 - i), $sformatf("rd%0d", i));
    req(1'b0, 1'b1, 32'h0, 0, 0, 0, 1, 32'h88, 4'd0, "rd_when_empty");

    // Pointer wrap
    for (int i = 0; i < 5; i++)
      req(1'b1, 1'b0, 32'(32'hA0 + i), 1, 0, 0, 0, 32'h88, 4'(i + 1), $sformatf("wrapA_wr%0d", i));
    for (int i = 0; i < 5; i++)
      req(1'b0, 1'b1, 32'h0, 0, 0, 1, 0, 32'(32'hA0 + i), 4'(4 - i), $sformatf("wrapA_rd%0d", i));
    for (int i = 0; i < 6; i++)
      req(1'b1, 1'b0, 32'(32'hB0 + i), 1, 0, 0, 0, 32'hA4, 4'(i + 1), $sformatf("wrapB_wr%0d", i));
    for (int i = 0; i < 6; i++)
      req(1'b0, 1'b1, 32'h0, 0, 0, 1, 0, 32'(32'hB0 + i), 4'(5 - i), $sformatf("wrapB_rd%0d", i));

    // Simultaneous write and read at empty, mid-level and full
    req(1'b1, 1'b1, 32'hC1, 1, 0, 0, 1, 32'hB5, 4'd1, "both_empty");
    req(1'b1, 1'b0, 32'hC2, 1, 0, 0, 0, 32'hB5, 4'd2, "sim_wrC2");
    req(1'b1, 1'b0, 32'hC3, 1, 0, 0, 0, 32'hB5, 4'd3, "sim_wrC3");
    req(1'b1, 1'b1, 32'hC4, 1, 0, 1, 0, 32'hC1, 4'd3, "both_mid");
    for (int i = 0; i < 5; i++)
      req(1'b1, 1'b0, 32'(32'hC5 + i), 1, 0, 0, 0, 32'hC1, 4'(4 + i), $sformatf("sim_fill%0d", i));
    req(1'b1, 1'b1, 32'hCA, 0, 1, 1, 0, 32'hC2, 4'd7, "both_full");
    for (int i = 0; i < 7; i++)
      req(1'b0, 1'b1, 32'h0, 0, 0, 1, 0, 32'(32'hC3 + i), 4'(6 - i), $sformatf("sim_drain%0d", i));

    // Asynchronous reset mid-cycle with four words stored
    for (int i = 0; i < 4; i++)
      req(1'b1, 1'b0, 32'(32'hD1 + i), 1, 0, 0, 0, 32'hC9, 4'(i + 1), $sformatf("pre_rst_wr%0d", i));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    #1;
    check_idle_state("async_reset", 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    req(1'b0, 1'b1, 32'h0, 0, 0, 0, 1, 32'h0, 4'd0, "rd_after_reset");
    idle();

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
